// File: rtl/glb_loader.sv
// DMA loader: streams a contiguous block of words from external SRAM into the GLB.
// One SRAM read per cycle; each word is written to the GLB two cycles after its read.
module glb_loader #(
  parameter int BITWIDTH         = 16,
  parameter int SRAM_ADDR_LENGTH = 8,
  parameter int GLB_ADDR_LENGTH  = 8
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        start,
  input  logic [SRAM_ADDR_LENGTH-1:0] src_addr,
  input  logic [GLB_ADDR_LENGTH-1:0]  dst_addr,
  input  logic [GLB_ADDR_LENGTH:0]    length,
  output logic                        busy,
  output logic                        done,
  input  logic [BITWIDTH-1:0]         sram_rdata,
  output logic [SRAM_ADDR_LENGTH-1:0] sram_addr,
  output logic                        sram_cs,
  output logic                        sram_oe,
  output logic                        sram_we,
  output logic [GLB_ADDR_LENGTH-1:0]  glb_addr,
  output logic [BITWIDTH-1:0]         glb_wdata,
  output logic                        glb_cs,
  output logic                        glb_we,
  output logic                        glb_oe
);

  // state  | meaning
  // IDLE   | waiting for start
  // STREAM | one SRAM read issued per cycle, GLB writes trail by two cycles
  // DRAIN  | reads finished, completing the trailing GLB writes
  // DONE   | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam logic [GLB_ADDR_LENGTH:0] CNT_ONE = (GLB_ADDR_LENGTH+1)'(1);

  state_t                        state_q;
  logic [GLB_ADDR_LENGTH:0]      rd_cnt_q;
  logic [GLB_ADDR_LENGTH:0]      wr_cnt_q;
  logic [SRAM_ADDR_LENGTH-1:0]   sram_addr_q;
  logic                          sram_cs_q;
  logic                          rvld_q;
  logic [GLB_ADDR_LENGTH-1:0]    wr_addr_q;
  logic [GLB_ADDR_LENGTH-1:0]    glb_addr_q;
  logic [BITWIDTH-1:0]           glb_wdata_q;
  logic                          glb_cs_q;
  logic                          busy_q;
  logic                          done_q;

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      sram_addr_q <= '0;
      sram_cs_q   <= 1'b0;
      rvld_q      <= 1'b0;
      wr_addr_q   <= '0;
      glb_addr_q  <= '0;
      glb_wdata_q <= '0;
      glb_cs_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // rvld_q marks the cycle in which sram_rdata carries a requested word
      rvld_q   <= sram_cs_q;
      glb_cs_q <= rvld_q;
      done_q   <= 1'b0;
      if (rvld_q) begin
        glb_addr_q  <= wr_addr_q;
        glb_wdata_q <= sram_rdata;
        wr_addr_q   <= wr_addr_q + GLB_ADDR_LENGTH'(1);
      end
      if (glb_cs_q) wr_cnt_q <= wr_cnt_q - CNT_ONE;

      case (state_q)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              sram_addr_q <= src_addr;
              sram_cs_q   <= 1'b1;
              wr_addr_q   <= dst_addr;
              rd_cnt_q    <= length;
              wr_cnt_q    <= length;
              busy_q      <= 1'b1;
              state_q     <= STREAM;
            end
          end
        end
        STREAM: begin
          rd_cnt_q <= rd_cnt_q - CNT_ONE;
          if (rd_cnt_q == CNT_ONE) begin
            sram_cs_q <= 1'b0;
            state_q   <= DRAIN;
          end else begin
            sram_addr_q <= sram_addr_q + SRAM_ADDR_LENGTH'(1);
          end
        end
        DRAIN: begin
          if (glb_cs_q && wr_cnt_q == CNT_ONE) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sram_addr = sram_addr_q;
  assign sram_cs   = sram_cs_q;
  assign sram_oe   = sram_cs_q;
  assign sram_we   = 1'b0;
  assign glb_addr  = glb_addr_q;
  assign glb_wdata = glb_wdata_q;
  assign glb_cs    = glb_cs_q;
  assign glb_we    = glb_cs_q;
  assign glb_oe    = 1'b0;

endmodule

// File: tb/tb_glb_loader.sv
// Scoreboard bench for glb_loader: each accepted start pushes the expected read, write
// and done events with their cycle numbers; a negedge monitor pops and compares them.
module tb_glb_loader;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [8:0]  length;
  logic        busy, done;
  logic [15:0] sram_rdata = '0;
  logic [7:0]  sram_addr;
  logic        sram_cs, sram_oe, sram_we;
  logic [7:0]  glb_addr;
  logic [15:0] glb_wdata;
  logic        glb_cs, glb_we, glb_oe;

  glb_loader dut (
    .clk(clk), .rstb(rstb), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .sram_rdata(sram_rdata),
    .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .glb_addr(glb_addr), .glb_wdata(glb_wdata), .glb_cs(glb_cs), .glb_we(glb_we),
    .glb_oe(glb_oe)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; int cyc; } rd_t;
  typedef struct { logic [7:0] addr; logic [15:0] data; int cyc; } wr_t;

  rd_t rq[$];
  wr_t wq[$];
  int  dq[$];

  logic [15:0] sram_mem  [256];
  logic [15:0] model_glb [256];
  logic [15:0] glb_img   [256];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int busy_lo = 0, busy_hi = -1;
  int done_cyc = -1;
  int exp_done = 0;
  int n_rd = 0, n_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: read data appears the cycle after the read is issued
  always @(posedge clk) if (sram_cs && sram_oe) sram_rdata <= sram_mem[sram_addr];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("sram_we_low", sram_we, 1'b0);
    chk("glb_oe_low", glb_oe, 1'b0);
    chk("glb_we_eq_cs", glb_we, glb_cs);
    chk("sram_oe_eq_cs", sram_oe, sram_cs);
    chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));

    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      chk("read_missing_cyc", cyc, rq[0].cyc);
      void'(rq.pop_front());
    end
    if (sram_cs) begin
      n_rd++;
      if (rq.size() == 0 || rq[0].cyc != cyc) chk("read_unexpected", sram_cs, 1'b0);
      else begin
        chk("read_addr", sram_addr, rq[0].addr);
        void'(rq.pop_front());
      end
    end

    while (wq.size() > 0 && wq[0].cyc < cyc) begin
      chk("write_missing_cyc", cyc, wq[0].cyc);
      void'(wq.pop_front());
    end
    if (glb_cs && glb_we) begin
      n_wr++;
      glb_img[glb_addr] = glb_wdata;
      if (wq.size() == 0 || wq[0].cyc != cyc) chk("write_unexpected", glb_cs, 1'b0);
      else begin
        chk("write_addr", glb_addr, wq[0].addr);
        chk("write_data", glb_wdata, wq[0].data);
        void'(wq.pop_front());
      end
    end

    while (dq.size() > 0 && dq[0] < cyc) begin
      chk("done_missing_cyc", cyc, dq[0]);
      void'(dq.pop_front());
    end
    if (done) begin
      done_cyc = cyc;
      if (dq.size() == 0 || dq[0] != cyc) chk("done_unexpected", done, 1'b0);
      else begin
        chk("done_cycle", cyc, dq[0]);
        void'(dq.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference model: the transfer expressed as a list of timed events.
  task automatic do_start(input logic [7:0] s_a, input logic [7:0] d_a, input int len);
    int s;
    logic [7:0] a, w;
    s = cyc;
    start = 1'b1; src_addr = s_a; dst_addr = d_a; length = 9'(len);
    for (int k = 0; k < len; k++) begin
      a = s_a + 8'(k);
      w = d_a + 8'(k);
      rq.push_back('{a, s + 1 + k});
      wq.push_back('{w, sram_mem[a], s + 3 + k});
      model_glb[w] = sram_mem[a];
    end
    exp_done = (len == 0) ? s + 1 : s + len + 3;
    dq.push_back(exp_done);
    if (len > 0) begin busy_lo = s + 1; busy_hi = s + len + 2; end
    done_cyc = -1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_start_ignored();
    start = 1'b1;
    src_addr = 8'($urandom); dst_addr = 8'($urandom); length = 9'($urandom_range(1, 8));
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int lim = 400;
    while (cyc <= exp_done && lim > 0) begin step(); lim--; end
    if (lim == 0) chk("wait_timeout", cyc, exp_done);
  endtask

  task automatic check_zero(input string name);
    chk(name, {busy, done, sram_addr, sram_cs, sram_oe, sram_we, glb_addr, glb_wdata,
               glb_cs, glb_we, glb_oe}, '0);
  endtask

  initial begin
    int s, r0, w0, mism, len;
    logic [7:0] sa, da;
    rstb = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 16'($urandom); model_glb[i] = '0; glb_img[i] = '0;
    end
    repeat (3) step();
    check_zero("reset_outputs");
    rstb = 1'b0;
    step();

    // basic transfer
    sram_mem[8'h10] = 16'hAAAA; sram_mem[8'h11] = 16'hBBBB;
    sram_mem[8'h12] = 16'hCCCC; sram_mem[8'h13] = 16'hDDDD;
    s = cyc; w0 = n_wr;
    do_start(8'h10, 8'h40, 4);
    wait_done();
    chk("basic_done_latency", done_cyc - s, 7);
    chk("basic_write_count", n_wr - w0, 4);
    chk("basic_glb40", glb_img[8'h40], 16'hAAAA);
    chk("basic_glb43", glb_img[8'h43], 16'hDDDD);

    // zero length
    s = cyc; r0 = n_rd; w0 = n_wr;
    do_start(8'h33, 8'h55, 0);
    wait_done();
    chk("zero_done_latency", done_cyc - s, 1);
    chk("zero_reads", n_rd - r0, 0);
    chk("zero_writes", n_wr - w0, 0);

    // wrap and full buffer
    s = cyc;
    do_start(8'hFE, 8'hFF, 256);
    wait_done();
    chk("wrap_done_latency", done_cyc - s, 259);
    chk("wrap_glbFF", glb_img[8'hFF], sram_mem[8'hFE]);
    chk("wrap_glb00", glb_img[8'h00], sram_mem[8'hFF]);

    // back-to-back requests: busy and done-cycle starts are ignored
    s = cyc;
    do_start(8'h20, 8'h80, 5);
    step();
    pulse_start_ignored();
    while (cyc < s + 8) step();
    pulse_start_ignored();
    chk("b2b_third_cycle", cyc, s + 9);
    do_start(8'h60, 8'hA0, 3);
    wait_done();
    chk("b2b_third_latency", done_cyc - (s + 9), 6);

    // random data integrity
    for (int it = 0; it < 100; it++) begin
      for (int i = 0; i < 256; i++) sram_mem[i] = 16'($urandom);
      sa = 8'($urandom); da = 8'($urandom); len = $urandom_range(0, 32);
      do_start(sa, da, len);
      wait_done();
      mism = 0;
      for (int i = 0; i < 256; i++) if (glb_img[i] !== model_glb[i]) mism++;
      chk("image_mismatches", mism, 0);
      repeat ($urandom_range(0, 2)) step();
    end

    // reset mid-transfer
    s = cyc;
    do_start(8'h05, 8'hC0, 8);
    while (cyc < s + 5) step();
    rstb = 1'b1;
    rq.delete(); wq.delete(); dq.delete();
    busy_hi = -1;
    step();
    check_zero("reset_mid_cycle6");
    rstb = 1'b0;
    step();
    check_zero("reset_mid_cycle7");
    repeat (10) step();
    chk("reset_no_done", done_cyc, -1);
    s = cyc;
    do_start(8'h70, 8'h10, 2);
    wait_done();
    chk("post_reset_latency", done_cyc - s, 5);
    chk("post_reset_glb10", glb_img[8'h10], sram_mem[8'h70]);
    chk("post_reset_glb11", glb_img[8'h11], sram_mem[8'h71]);

    repeat (3) step();
    chk("reads_drained", rq.size(), 0);
    chk("writes_drained", wq.size(), 0);
    chk("dones_drained", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/glb_loader.md
# glb_loader

DMA engine that copies a contiguous block of words from the external SRAM into the global buffer (GLB) of `ml_accelerator`. It sits directly upstream of the GLB: it drives the external SRAM read port and the GLB write port. Transfers are fully pipelined at one word per cycle after a fixed fill latency. The accelerator controller starts each transfer with a one-cycle `start` pulse and waits for a one-cycle `done` pulse.

## Interface
Parameters:
- `BITWIDTH`, 16: word width.
- `SRAM_ADDR_LENGTH`, 8: external SRAM address width.
- `GLB_ADDR_LENGTH`, 8: GLB address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstb`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle transfer request; sampled only in IDLE.
- `src_addr`  in  SRAM_ADDR_LENGTH  first SRAM word address; sampled with `start`.
- `dst_addr`  in  GLB_ADDR_LENGTH  first GLB word address; sampled with `start`.
- `length`  in  GLB_ADDR_LENGTH+1  word count, 0..2^GLB_ADDR_LENGTH; sampled with `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `sram_rdata`  in  BITWIDTH  SRAM read data, valid the cycle after a read issue.
- `sram_addr`  out  SRAM_ADDR_LENGTH  SRAM address.
- `sram_cs`, `sram_oe`  out  1 each  SRAM chip select and output enable.
- `sram_we`  out  1  SRAM write enable; always 0.
- `glb_addr`  out  GLB_ADDR_LENGTH  GLB address.
- `glb_wdata`  out  BITWIDTH  GLB write data.
- `glb_cs`, `glb_we`  out  1 each  GLB select and write enable; always equal.
- `glb_oe`  out  1  GLB output enable; always 0.

## Operation
- All outputs are registered. Reset value of every output is 0.
- FSM states:
  - IDLE: accepts `start`. If `length`=0, go to DONE. Otherwise latch the inputs, load the read counter `rd_cnt` and the write counter `wr_cnt` with `length`, and go to STREAM.
  - STREAM: issues one SRAM read per cycle. The read address is the latched `src_addr` plus an offset that increments by 1. Leave for DRAIN when the last read is issued.
  - DRAIN: completes the outstanding GLB writes. Go to DONE when `wr_cnt` reaches 0.
  - DONE: `done`=1 for exactly one cycle, then return to IDLE.
- Data path:
  - SRAM word k returns on `sram_rdata` one cycle after its read issue.
  - The loader captures it at the end of that cycle.
  - In the next cycle it drives `glb_addr`=dst+k, `glb_wdata`=word k, and `glb_cs`=`glb_we`=1.
  - Writes happen in both STREAM and DRAIN. `wr_cnt` decrements once per write.
- Address arithmetic is modulo 2^width on both sides. Example: dst=0xFF with `length`=2 writes GLB 0xFF, then 0x00. No error is flagged on wrap.
- `length`=2^GLB_ADDR_LENGTH (256 at default) is legal and fills the entire GLB.
- `start` while busy or in DONE is ignored. No queueing.
- `rstb` asserted mid-transfer: at the next edge the FSM returns to IDLE and all strobes drop to 0. The in-flight word is discarded and `done` is not pulsed.
- `sram_we` and `glb_oe` are held at 0 at all times.

## Timing
Take `start` sampled at the end of cycle 0, with L>0.
- Cycles 1..L: `sram_cs`=`sram_oe`=1, `sram_addr`=src+(c-1).
- Cycles 3..L+2: GLB write of word c-3. Reads and writes overlap from cycle 3 onward.
- Cycle L+3: `done`=1.
- `busy`=1 in cycles 1..L+2. `busy`=0 in the `done` cycle.
- Total latency from start to `done` is L+3 cycles. Throughput is 1 word/cycle.
- `length`=0: `done`=1 in cycle 1. No SRAM or GLB strobes. `busy` never rises.
- A new `start` is accepted in the first cycle after `done`, i.e. cycle L+4.

## Test plan
- Basic transfer:
  - Stimulus: SRAM[0x10..0x13]=A,B,C,D; start with src=0x10, dst=0x40, L=4.
  - Required: GLB[0x40..0x43]=A..D; `done` in cycle 7; exactly 4 GLB writes; `sram_we`=0 throughout.
- Zero length:
  - Stimulus: start with L=0.
  - Required: `done` in cycle 1; no `sram_cs` or `glb_cs` pulses; `busy` stays 0.
- Wrap and full buffer:
  - Stimulus: start with src=0xFE, dst=0xFF, L=256.
  - Required: SRAM reads 0xFE, 0xFF, 0x00, ...; GLB write 0 goes to 0xFF and write 1 to 0x00; `done` in cycle 259.
- Back-to-back requests:
  - Stimulus: second `start` during `busy` and in the `done` cycle, then a third `start` in cycle L+4.
  - Required: the first two are ignored; the third is accepted and completes normally.
- Reset mid-transfer:
  - Stimulus: L=8, assert `rstb` in cycle 5.
  - Required: all outputs 0 from cycle 6; no `done`; a subsequent start with L=2 completes correctly.
- Data integrity:
  - Stimulus: random src, dst, L≤32 with random SRAM contents, 100 iterations.
  - Required: scoreboard matches the GLB image exactly and no GLB address outside the window is written.
